reg_file_2r1w: RTL and testbench

//  32-entry general-purpose register file for the CPU datapath: two read ports, one write port.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/reg_file_2r1w_if.sv | 33 +++
 rtl/reg_file_2r1w.sv | 81 ++++++++
 tb/tb_reg_file_2r1w.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides the register-address and machine-word widths, the hard-wired
// zero register index, and the matching typedefs. The datapath top, mux32
// and the register file all use these names.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: two read ports and one write port.
// There is no valid/ready handshake. A read is a purely combinational
// address -> data lookup. A write is a single-cycle request: it is taken on
// the rising clk edge whenever we=1, and it cannot stall.
//   raddr1/raddr2 : read addresses        (master -> slave)
//   rdata1/rdata2 : read data             (slave  -> master)
//   we/waddr/wdata: write request         (master -> slave)
interface reg_file_2r1w_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
);

    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output raddr1, raddr2, we, waddr, wdata,
        input  rdata1, rdata2
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata,
        output rdata1, rdata2
    );

endinterface

// File: rtl/reg_file_2r1w.sv
// 32-entry general-purpose register file: two asynchronous read ports and
// one synchronous write port. Register 0 always reads as zero.
// When BYPASS=1, a write presented in the current cycle is forwarded to any
// read port whose address matches it, before the clock edge.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset; clears every register
//   rf    : reg_file_2r1w_if.slave (raddr1/2, rdata1/2, we, waddr, wdata)
module reg_file_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_2r1w_if.slave  rf
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 exists only to keep indexing simple. It is reset to zero and
    // never written, so it folds to a constant.
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // The write is decoded one entry at a time and uses an equality test
    // against a known 1. If we or waddr is X, every compare evaluates to X,
    // so the if-branch is not taken and no entry is disturbed.
    always_comb begin
        regs_d[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if ((rf.we == 1'b1) && (rf.waddr == ADDR_W'(i))) begin
                regs_d[i] = rf.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // One read port. Address 0 never bypasses. The rst_n gate keeps a
    // write that is pending during reset from leaking through the bypass.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_ok,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] value;
        value = '0;
        if (rst_ok && (ra != '0)) begin
            value = stored;
            if ((BYPASS != 0) && (wr_en == 1'b1) && (wr_addr == ra)) begin
                value = wr_data;
            end
        end
        return value;
    endfunction

    always_comb begin
        rf.rdata1 = read_port(rst_n, rf.raddr1, regs_q[rf.raddr1],
                              rf.we, rf.waddr, rf.wdata);
        rf.rdata2 = read_port(rst_n, rf.raddr2, regs_q[rf.raddr2],
                              rf.we, rf.waddr, rf.wdata);
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w. Two instances, one with BYPASS=1 and one
// with BYPASS=0, receive identical stimulus. Both are checked against an
// array model of the architectural register contents.
module tb_reg_file_2r1w;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic        we_t;
  logic [4:0]  waddr_t, ra1_t, ra2_t;
  logic [31:0] wdata_t;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if_b1 ();
  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if_b0 ();

  assign if_b1.we = we_t;  assign if_b1.waddr = waddr_t;  assign if_b1.wdata = wdata_t;
  assign if_b1.raddr1 = ra1_t;  assign if_b1.raddr2 = ra2_t;
  assign if_b0.we = we_t;  assign if_b0.waddr = waddr_t;  assign if_b0.wdata = wdata_t;
  assign if_b0.raddr1 = ra1_t;  assign if_b0.raddr2 = ra2_t;

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .rf(if_b1)
  );
  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .rf(if_b0)
  );

  // obs index: 0 = b1.rdata1, 1 = b1.rdata2, 2 = b0.rdata1, 3 = b0.rdata2
  logic [31:0] obs [4];
  assign obs[0] = if_b1.rdata1;
  assign obs[1] = if_b1.rdata2;
  assign obs[2] = if_b0.rdata1;
  assign obs[3] = if_b0.rdata2;

  // ---------------- reference model ----------------
  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  // What a read should return right now, from the architectural rules.
  function automatic logic [31:0] exp_rd(input bit bypass, input logic [4:0] ra);
    if (!rst_n || ra == 5'd0) return 32'h0;
    if (bypass && we_t && waddr_t == ra) return wdata_t;
    return model[ra];
  endfunction

  function automatic logic [31:0] exp_port(input int k);
    return exp_rd(k < 2, (k % 2 == 0) ? ra1_t : ra2_t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    we_t = we; waddr_t = wa; wdata_t = wd; ra1_t = a1; ra2_t = a2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Commit the pending write to the model, then advance past the edge.
  task automatic tick();
    if (rst_n && we_t && waddr_t != 5'd0) model[waddr_t] = wdata_t;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    drive(1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd4);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++; $display("FAIL reset_hold port%0d got %h exp %h", k, obs[k], 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b1, 5'(a), $urandom | 32'h1, 5'd0, 5'd0);
      tick();
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== exp_port(k)) begin
        errors++; $display("FAIL loaded port%0d got %h exp %h", k, obs[k], exp_port(k));
      end
    end
    // Mid-cycle reset pulse: every register reads zero before the next clk.
    #2;
    rst_n = 1'b0;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      ra1_t = 5'(a); ra2_t = 5'(31 - a);
      #0.1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== 32'h0) begin
          errors++; $display("FAIL reset_async a%0d port%0d got %h exp %h", a, k, obs[k], 32'h0);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd5);
    #1;
    checks++;
    if (if_b1.rdata2 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wr_rd_b1 got %h exp %h", if_b1.rdata2, 32'hFFFF_FFFF);
    end
    checks++;
    if (if_b0.rdata2 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wr_rd_b0 got %h exp %h", if_b0.rdata2, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_zero_reg();
    // Write to address 0 while reading it: the bypass condition.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++; $display("FAIL zero_bypass port%0d got %h exp %h", k, obs[k], 32'h0);
      end
    end
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++; $display("FAIL zero_stored port%0d got %h exp %h", k, obs[k], 32'h0);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = (k < 2) ? 32'h1234_5678 : 32'h1;
      checks++;
      if (obs[k] !== e) begin
        errors++; $display("FAIL bypass_pre port%0d got %h exp %h", k, obs[k], e);
      end
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'h1234_5678) begin
        errors++; $display("FAIL bypass_post port%0d got %h exp %h", k, obs[k], 32'h1234_5678);
      end
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    drive(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd31);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== exp_port(k)) begin
        errors++; $display("FAIL iso_pre port%0d got %h exp %h", k, obs[k], exp_port(k));
      end
    end
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    #1;
    checks++;
    if (if_b0.rdata1 !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL iso_reg3 got %h exp %h", if_b0.rdata1, 32'hA5A5_A5A5);
    end
    checks++;
    if (if_b0.rdata2 !== 32'h0) begin
      errors++; $display("FAIL iso_reg31 got %h exp %h", if_b0.rdata2, 32'h0);
    end
    // Sweep: every address holds addr * 0x01010101.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b1, 5'(a), 32'(a) * 32'h0101_0101, 5'd0, 5'd0);
      tick();
    end
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(32 - a));
      #1;
      for (int k = 0; k < 4; k++) begin
        logic [31:0] e;
        e = 32'((k % 2 == 0) ? a : 32 - a) * 32'h0101_0101;
        checks++;
        if (obs[k] !== e) begin
          errors++; $display("FAIL sweep a%0d port%0d got %h exp %h", a, k, obs[k], e);
        end
      end
    end
  endtask

  task automatic test_reset_during_write();
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h9999_0009, 5'd9, 5'd9);
    rst_n = 1'b0;
    clear_model();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++; $display("FAIL rst_wr port%0d got %h exp %h", k, obs[k], 32'h0);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) ra2_t = waddr_t;
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== exp_port(k)) begin
          errors++; $display("FAIL random n%0d port%0d got %h exp %h", n, k, obs[k], exp_port(k));
        end
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_isolation();
    test_reset_during_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
